// File: rtl/quad_trackball.sv
// quad_trackball: per-axis signed move packets -> saturating backlog -> rate-scaled quadrature A/B plus dir/step_clk, sticky overflow, busy
module quad_trackball #(
  parameter int NUM_AXES     = 2,
  parameter int COUNT_W      = 12,
  parameter int PERIOD_W     = 16,
  parameter int MIN_PERIOD   = 3000,
  parameter int FAST_THRESH  = 255,
  parameter int PERIOD_SHIFT = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  delta_valid,
  input  logic [8*NUM_AXES-1:0] delta,
  input  logic [1:0]            speed,
  input  logic [NUM_AXES-1:0]   invert,
  input  logic                  clear,
  output logic [NUM_AXES-1:0]   quad_a,
  output logic [NUM_AXES-1:0]   quad_b,
  output logic [NUM_AXES-1:0]   dir,
  output logic [NUM_AXES-1:0]   step_clk,
  output logic [NUM_AXES-1:0]   overflow,
  output logic [NUM_AXES-1:0]   busy
);
  localparam int SW = COUNT_W + 2;
  localparam logic signed [SW-1:0] LIM = SW'((1 << (COUNT_W - 1)) - 1);
  for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
    logic signed [8:0] d_ext;
    logic [8:0] d_mag;
    logic [9:0] s_mag;
    logic signed [SW-1:0] s_ext, add, dec, sum;
    logic signed [COUNT_W-1:0] pend, pend_n;
    logic [COUNT_W-1:0] p_mag;
    logic [31:0] slow;
    logic [PERIOD_W-1:0] cnt, period;
    logic [1:0] idx, idx_n;
    logic step, neg, sat, qa, qb, dr, sc, ov, bz;
    assign d_ext = {delta[8*i+7], delta[8*i +: 8]};
    assign d_mag = d_ext[8] ? 9'(-d_ext) : 9'(d_ext);
    assign s_mag = speed == 2'd0 ? {3'b0, d_mag[8:2]} : speed == 2'd1 ? {2'b0, d_mag[8:1]} :
                   speed == 2'd2 ? {1'b0, d_mag} : {d_mag, 1'b0};
    assign s_ext = SW'(s_mag);
    assign add = !delta_valid ? '0 : d_ext[8] ? -s_ext : s_ext;
    assign p_mag = pend[COUNT_W-1] ? COUNT_W'(-pend) : COUNT_W'(pend);
    assign slow = 32'(p_mag) >= 32'(FAST_THRESH) ? 32'd0 : 32'(FAST_THRESH) - 32'(p_mag);
    assign period = PERIOD_W'(32'(MIN_PERIOD) + (slow << PERIOD_SHIFT));
    assign step = pend != '0 && cnt >= period && !clear;
    assign neg = pend[COUNT_W-1] ^ invert[i];
    // a step always moves the backlog one toward zero, whatever the invert setting
    assign dec = !step ? '0 : pend[COUNT_W-1] ? -SW'(1) : SW'(1);
    assign sum = SW'(pend) + add - dec;
    assign sat = sum > LIM || sum < -LIM;
    assign pend_n = clear ? '0 : sum > LIM ? COUNT_W'(LIM) : sum < -LIM ? COUNT_W'(-LIM) : COUNT_W'(sum);
    assign idx_n = neg ? idx - 2'd1 : idx + 2'd1;
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        pend <= '0;
        cnt  <= '0;
        idx  <= '0;
        qa   <= 1'b0;
        qb   <= 1'b0;
        dr   <= 1'b0;
        sc   <= 1'b0;
        ov   <= 1'b0;
        bz   <= 1'b0;
      end else begin
        pend <= pend_n;
        cnt  <= clear || pend == '0 || step ? '0 : cnt + 1'b1;
        ov   <= clear ? 1'b0 : ov | sat;
        bz   <= pend_n != '0;
        if (step) begin
          idx <= idx_n;
          qa  <= idx_n[1] ^ idx_n[0];
          qb  <= idx_n[1];
          dr  <= neg;
          sc  <= ~sc;
        end
      end
    assign quad_a[i]   = qa;
    assign quad_b[i]   = qb;
    assign dir[i]      = dr;
    assign step_clk[i] = sc;
    assign overflow[i] = ov;
    assign busy[i]     = bz;
  end
endmodule

// File: tb/tb_quad_trackball.sv
// tb_quad_trackball: directed vectors with hand-computed step timing and quadrature sequences
module tb_quad_trackball;
  logic clk = 1'b0, reset_n = 1'b0, delta_valid = 1'b0, clear = 1'b0;
  logic [15:0] delta = '0;
  logic [1:0] speed = 2'd2, invert = '0;
  logic [1:0] quad_a, quad_b, dir, step_clk, overflow, busy;
  int checks = 0, errors = 0;
  int n;
  logic [1:0] rev_exp [5] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
  quad_trackball #(
    .NUM_AXES(2), .COUNT_W(8), .PERIOD_W(16), .MIN_PERIOD(4), .FAST_THRESH(8), .PERIOD_SHIFT(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .delta_valid(delta_valid), .delta(delta), .speed(speed),
    .invert(invert), .clear(clear), .quad_a(quad_a), .quad_b(quad_b), .dir(dir),
    .step_clk(step_clk), .overflow(overflow), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] d0, input logic [7:0] d1);
    delta = {d1, d0};
    delta_valid = 1'b1;
    tick(1);
    delta_valid = 1'b0;
    delta = '0;
  endtask
  task automatic wait_step(input int ax, output int cyc);
    logic s0;
    s0 = step_clk[ax];
    cyc = 0;
    do begin
      tick(1);
      cyc++;
    end while (step_clk[ax] == s0 && cyc < 300);
  endtask
  task automatic hard_reset();
    reset_n = 1'b0;
    invert = '0;
    speed = 2'd2;
    clear = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(1);
  endtask
  function automatic logic [1:0] ab(input int ax);
    return {quad_a[ax], quad_b[ax]};
  endfunction
  initial begin
    #12;
    check("reset_outs", {quad_a, quad_b, dir, step_clk, overflow, busy}, 0);
    reset_n = 1'b1;
    tick(1);
    // positive run: +3 -> P = 9,10,11
    send(8'd3, 8'd0);
    check("pos_busy", busy[0], 1);
    wait_step(0, n); check("pos_int1", n, 10); check("pos_ab1", ab(0), 2'b10); check("pos_dir", dir[0], 0);
    wait_step(0, n); check("pos_int2", n, 11); check("pos_ab2", ab(0), 2'b11);
    wait_step(0, n); check("pos_int3", n, 12); check("pos_ab3", ab(0), 2'b01);
    check("pos_sclk", step_clk[0], 1); check("pos_idle", busy[0], 0);
    // negative on axis1: -5 at speed 1 -> -2
    speed = 2'd1;
    send(8'd0, 8'hFB);
    wait_step(1, n); check("neg_int1", n, 11); check("neg_ab1", ab(1), 2'b01); check("neg_dir", dir[1], 1);
    wait_step(1, n); check("neg_int2", n, 12); check("neg_ab2", ab(1), 2'b11); check("neg_idle", busy[1], 0);
    check("neg_ax0_hold", ab(0), 2'b01);
    // same with invert on axis1
    hard_reset();
    invert = 2'b10;
    speed = 2'd1;
    send(8'd0, 8'hFB);
    wait_step(1, n); check("inv_int1", n, 11); check("inv_ab1", ab(1), 2'b10); check("inv_dir", dir[1], 0);
    wait_step(1, n); check("inv_int2", n, 12); check("inv_ab2", ab(1), 2'b11); check("inv_idle", busy[1], 0);
    // saturation: three +127 at speed 3 clamp to +127
    hard_reset();
    speed = 2'd3;
    delta = {8'd0, 8'd127};
    delta_valid = 1'b1;
    tick(3);
    delta_valid = 1'b0;
    delta = '0;
    check("sat_ovf", overflow, 2'b01);
    n = 0;
    for (int k = 0; k < 5000 && busy[0]; k++) begin
      logic s0;
      s0 = step_clk[0];
      tick(1);
      if (step_clk[0] != s0) n++;
    end
    check("sat_steps", n, 127);
    check("sat_ab", ab(0), 2'b01);
    check("sat_sticky", overflow[0], 1);
    clear = 1'b1; tick(1); clear = 1'b0;
    check("clr_ovf", overflow[0], 0); check("clr_ab", ab(0), 2'b01);
    // delta arriving in the same cycle as a step on pending=+1
    hard_reset();
    send(8'd1, 8'd0);
    tick(11);
    delta = {8'd0, 8'd1};
    delta_valid = 1'b1;
    tick(1);
    delta_valid = 1'b0;
    delta = '0;
    check("sim_step", step_clk[0], 1); check("sim_busy", busy[0], 1);
    wait_step(0, n); check("sim_int", n, 12); check("sim_idle", busy[0], 0);
    // clear in the same cycle a step would fire
    hard_reset();
    send(8'd1, 8'd0);
    tick(11);
    clear = 1'b1; tick(1); clear = 1'b0;
    check("clrstep_busy", busy[0], 0); check("clrstep_sclk", step_clk[0], 0);
    tick(30);
    check("clrstep_quiet", step_clk[0], 0);
    // clear wins over delta_valid
    clear = 1'b1; delta = {8'd0, 8'd5}; delta_valid = 1'b1;
    tick(1);
    clear = 1'b0; delta_valid = 1'b0; delta = '0;
    check("clr_drop", busy[0], 0);
    // reversal with concurrent axis1 traffic
    hard_reset();
    send(8'd2, 8'd0);
    wait_step(0, n); check("rev_first", ab(0), 2'b10);
    send(8'hFA, 8'd3);
    for (int k = 0; k < 5; k++) begin
      wait_step(0, n);
      check($sformatf("rev_ab%0d", k), ab(0), rev_exp[k]);
    end
    check("rev_dir", dir[0], 1); check("rev_idle", busy[0], 0);
    for (int k = 0; k < 300 && busy[1]; k++) tick(1);
    check("rev_ax1_ab", ab(1), 2'b01); check("rev_ax1_idle", busy[1], 0);
    // asynchronous reset while stepping with pending=+40
    hard_reset();
    send(8'd40, 8'd0);
    wait_step(0, n); check("ar_int", n, 5); check("ar_ab", ab(0), 2'b10);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_outs", {quad_a, quad_b, dir, step_clk, overflow, busy}, 0);
    tick(1);
    reset_n = 1'b1;
    tick(30);
    check("ar_quiet", {step_clk, busy}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
